// File: rtl/rr_arbiter16.sv
// rr_arbiter16 -- sixteen-requester round-robin arbiter with a hold-time limit.
//
// Shares one downstream resource among requesters 0..15. The request vector
// is rotated so that the current priority pointer lands at bit 0. A 16-to-4
// priority encode of the rotated vector then finds the winner. One grant is
// issued at a time and is held until the holder releases it, or until the
// hold-time limit forces it off.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   en         in   1   arbiter enable; dropping it ends an active grant
//   req        in  16   request vector, bit i = requester i
//   rel        in   1   release strobe from the current holder
//   gnt_valid  out  1   a grant is active
//   gnt_idx    out  4   index of the granted requester (kept after grant end)
//   gnt        out 16   one-hot grant, zero when gnt_valid=0
//   ptr        out  4   highest-priority index for the next arbitration
//   timeout    out  1   one-cycle pulse when the hold limit ends a grant
//
// Parameter
//   MAX_HOLD   maximum cycles a grant may stay asserted (1..255), 0 = no limit
module rr_arbiter16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        rel,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt,
  output logic [3:0]  ptr,
  output logic        timeout
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Index of the lowest set bit. The result is 0 when the vector is empty,
  // so callers qualify it with a separate any-request flag.
  function automatic logic [3:0] prio_enc16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_e      state_q, state_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic [3:0]  gnt_idx_q, gnt_idx_d;
  logic [15:0] gnt_q, gnt_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  hold_q, hold_d;

  // Rotate the request vector so requester ptr sits at bit 0. Bit j of
  // req_rot is then requester (ptr+j) mod 16. The first set bit of req_rot
  // is therefore the first requester found when the search starts at ptr.
  logic [31:0] req_dbl;
  logic [15:0] req_rot;
  logic [3:0]  rot_win;
  logic [3:0]  pick_idx;
  logic        any_req;

  assign req_dbl  = {req, req} >> ptr_q;
  assign req_rot  = req_dbl[15:0];
  assign rot_win  = prio_enc16(req_rot);
  assign pick_idx = ptr_q + rot_win;   // 4-bit add wraps mod 16
  assign any_req  = |req;

  // Grant-end causes. A release-type cause takes precedence over the limit
  // for the timeout flag, so the limit pulse fires only when nothing else
  // ended the grant.
  logic rel_cause;
  logic limit_hit;

  assign rel_cause = rel | ~req[gnt_idx_q] | ~en;
  assign limit_hit = HOLD_EN && (hold_q == HOLD_LIM);

  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    timeout_d   = 1'b0;
    hold_d      = hold_q;

    case (state_q)
      IDLE: begin
        if (en && any_req) begin
          state_d     = GRANT;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = pick_idx;
          gnt_d       = 16'h0001 << pick_idx;
          hold_d      = 8'd1;
        end
      end
      GRANT: begin
        if (rel_cause || limit_hit) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          gnt_d       = 16'h0000;
          ptr_d       = gnt_idx_q + 4'd1;
          timeout_d   = limit_hit && !rel_cause;
        end else if (hold_q != 8'hFF) begin
          // The counter saturates, which only matters when there is no limit.
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= 4'd0;
      gnt_q       <= 16'h0000;
      ptr_q       <= 4'd0;
      timeout_q   <= 1'b0;
      hold_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      timeout_q   <= timeout_d;
      hold_q      <= hold_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt       = gnt_q;
  assign ptr       = ptr_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Sixteen-requester round-robin arbiter built around a 16-to-4 priority encode of the request vector. It shares one downstream resource among requesters 0..15, issuing one registered grant at a time with both a 4-bit index and a one-hot vector. Rotating priority prevents starvation, and a hold-time limit bounds how long any requester can keep the resource. It sits between the request sources and the shared resource it sequences.

## Interface
- MAX_HOLD, default 8: maximum cycles one grant may stay asserted. Legal range 1..255; 0 disables the limit.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  arbiter enable.
- req  in  16  request vector; bit i = requester i.
- rel  in  1  release strobe from the current grant holder.
- gnt_valid  out  1  a grant is active.
- gnt_idx  out  4  index of the granted requester.
- gnt  out  16  one-hot grant; all zero when gnt_valid=0.
- ptr  out  4  current highest-priority index, for debug.
- timeout  out  1  one-cycle pulse when a grant is force-ended by MAX_HOLD.

## Operation
- Reset (async, rst_n=0): state IDLE, gnt_valid=0, gnt_idx=0, gnt=0, ptr=0, timeout=0, hold counter=0. Reset asserted mid-grant drops the grant immediately, with no wait for a clock edge.
- States: IDLE and GRANT.
- IDLE:
  - If en=1 and req≠0, select k = first set req bit scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod-16 wrap).
  - At that edge: gnt_valid←1, gnt_idx←k, gnt←1<<k, hold counter←1, state←GRANT.
  - rel is ignored in IDLE.
- GRANT: the grant ends at an edge where any of the following holds:
  - rel=1;
  - req[k]=0, treated as a release;
  - en=0, treated as a release;
  - MAX_HOLD≠0 and hold counter = MAX_HOLD.
- GRANT, otherwise: the hold counter increments; it is 8 bits and saturates at 255 when MAX_HOLD=0.
- Grant end (same edge for all causes): gnt_valid←0, gnt←0, gnt_idx keeps its last value, ptr←(k+1) mod 16 (15 wraps to 0), state←IDLE.
- timeout: set to 1 for exactly one cycle, at the grant-end edge, only when the end is caused by the limit. If rel, req drop or en=0 coincides with the limit, the end counts as a release and timeout stays 0.
- Request changes on bits other than k during GRANT are ignored, with no preemption.
- ptr changes only at a grant end.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Grant latency: req/en sampled high at edge N in IDLE gives gnt_valid=1 after edge N.
- A grant ends at the edge that samples the end condition, so gnt_valid is low after that edge.
- Minimum one IDLE cycle (bubble) between consecutive grants. Back-to-back throughput is one grant per 2 cycles when each holder releases on its first grant cycle.
- With a limit, gnt_valid is high for at most MAX_HOLD consecutive cycles.

## Test plan
- Single requester: req=0x0020 from reset, rel pulsed on the 3rd grant cycle → gnt_valid rises one edge after req; gnt_idx=5, gnt=0x0020 for exactly 3 cycles; then ptr=6, timeout=0.
- Full rotation: req=0xFFFF held, rel=1 on every grant cycle → gnt_idx sequence 0,1,…,15,0,1, one grant every 2 cycles, ptr wraps 15→0.
- Wrap search: after granting 13 (ptr=14), set req=0x0009 with immediate releases → grant 0 first, then 3; ptr=1 after the first grant and 4 after the second.
- Timeout with MAX_HOLD=8: req=0x0014 held, no rel:
  - gnt_idx=2 high exactly 8 cycles, timeout pulses 1 cycle as gnt drops;
  - next grant is 4 after one bubble;
  - repeat the case with rel=1 on cycle 8 → no timeout pulse.
- Enable and req-drop:
  - en=0 with req=0xFFFF → no grant ever;
  - during a grant, drop en → grant ends at the next edge and ptr advances;
  - during a grant, drop req[k] → same behaviour.
- Async reset mid-grant: pull rst_n low between clock edges while gnt_idx=9 → gnt_valid=0, gnt=0, ptr=0 immediately; after release the first grant goes to the lowest set req bit.
